// File: rtl/i2c_rx_word_ctrl_pkg.sv
// Shared types and constants for the I2C receive word sequencer.
package i2c_rx_word_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ACK,
        DONE
    } state_e;

    localparam int unsigned SZ_BYTE = 8;
    localparam int unsigned SZ_HALF = 16;
    localparam int unsigned SZ_WORD = 32;

    function automatic logic is_legal_size(input logic [31:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

endpackage

// File: rtl/i2c_rx_word_ctrl.sv
// I2C receive word sequencer: counts sampled SDA bits, gates the receive
// shift buffer load, inserts ACK slots per byte and flags done/abort.
module i2c_rx_word_ctrl
    import i2c_rx_word_ctrl_pkg::*;
#(
    parameter bit          ACK_EN = 1'b1,
    parameter int unsigned SIZE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic              bit_strobe,
    input  logic              stop_det,
    output logic              rload,
    output logic [SIZE_W-1:0] size_o,
    output logic              ack_drive,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        bit_cnt
);

    state_e            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              err_q, err_d;

    logic [5:0]        cnt_inc;
    logic [SIZE_W-1:0] cnt_ext;
    logic [SIZE_W-1:0] cnt_inc_ext;

    assign cnt_inc     = bit_cnt_q + 6'd1;
    assign cnt_ext     = SIZE_W'(bit_cnt_q);
    assign cnt_inc_ext = SIZE_W'(cnt_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            size_q    <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_legal_size(32'(size))) begin
                        size_d    = size;
                        bit_cnt_d = '0;
                        state_d   = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // Abort wins over a coincident strobe; partial count is kept.
                if (stop_det) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bit_strobe) begin
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc[2:0] == 3'd0) begin
                        if (ACK_EN) begin
                            state_d = ACK;
                        end else if (cnt_inc_ext == size_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            ACK: begin
                if (stop_det) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bit_strobe) begin
                    state_d = (cnt_ext == size_q) ? DONE : RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rload     = (state_q == RECV) && bit_strobe;
    assign ack_drive = (state_q == ACK);
    assign busy      = (state_q == RECV) || (state_q == ACK);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign size_o    = size_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_i2c_rx_word_ctrl.sv
// Directed bench for i2c_rx_word_ctrl with and without ACK slots; a local
// shift register stands in for the receive buffer.
module tb_i2c_rx_word_ctrl;

    typedef struct {
        logic        is_err;
        logic [5:0]  cnt;
        logic [31:0] data;
        int unsigned width;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic [7:0] size = '0;
    logic       bit_strobe = 1'b0;
    logic       stop_det = 1'b0;
    logic       sda = 1'b0;

    logic       start_a, start_b, strobe_a, strobe_b, stop_a, stop_b;
    logic       rload_a, rload_b, ack_a, ack_b, busy_a, busy_b;
    logic       done_a, done_b, err_a, err_b;
    logic [7:0] size_o_a, size_o_b;
    logic [5:0] cnt_a, cnt_b;

    logic       rload_s, ack_s, busy_s, done_s, err_s;
    logic [7:0] size_o_s;
    logic [5:0] cnt_s;

    logic [31:0] rxbuf = '0;
    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          rl_cnt = 0;
    int          ackslot_cnt = 0;

    always #5 clk = ~clk;

    assign start_a  = sel ? 1'b0 : start;
    assign start_b  = sel ? start : 1'b0;
    assign strobe_a = sel ? 1'b0 : bit_strobe;
    assign strobe_b = sel ? bit_strobe : 1'b0;
    assign stop_a   = sel ? 1'b0 : stop_det;
    assign stop_b   = sel ? stop_det : 1'b0;

    assign rload_s  = sel ? rload_b  : rload_a;
    assign ack_s    = sel ? ack_b    : ack_a;
    assign busy_s   = sel ? busy_b   : busy_a;
    assign done_s   = sel ? done_b   : done_a;
    assign err_s    = sel ? err_b    : err_a;
    assign size_o_s = sel ? size_o_b : size_o_a;
    assign cnt_s    = sel ? cnt_b    : cnt_a;

    i2c_rx_word_ctrl #(.ACK_EN(1'b1), .SIZE_W(8)) u_ack (
        .clk(clk), .rst(rst), .start(start_a), .size(size),
        .bit_strobe(strobe_a), .stop_det(stop_a), .rload(rload_a),
        .size_o(size_o_a), .ack_drive(ack_a), .busy(busy_a),
        .done(done_a), .err(err_a), .bit_cnt(cnt_a)
    );

    i2c_rx_word_ctrl #(.ACK_EN(1'b0), .SIZE_W(8)) u_noack (
        .clk(clk), .rst(rst), .start(start_b), .size(size),
        .bit_strobe(strobe_b), .stop_det(stop_b), .rload(rload_b),
        .size_o(size_o_b), .ack_drive(ack_b), .busy(busy_b),
        .done(done_b), .err(err_b), .bit_cnt(cnt_b)
    );

    // Receive buffer stand-in: shifts on the negedge after rload, LSB first.
    always @(negedge clk) begin
        if (rload_s) rxbuf <= {sda, rxbuf[31:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // Called at a drive point (posedge+1); returns at the next drive point.
    task automatic send_start(input logic [7:0] sz);
        start = 1'b1;
        size  = sz;
        @(negedge clk);
        chk("busy_low_during_start", 32'(busy_s), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic strobe(input logic b, input logic st, input logic sp, output logic rl);
        bit_strobe = 1'b1;
        sda        = b;
        start      = st;
        stop_det   = sp;
        @(negedge clk);
        rl = rload_s;
        if (rload_s) rl_cnt++;
        if (ack_s) ackslot_cnt++;
        @(posedge clk); #1;
        bit_strobe = 1'b0;
        start      = 1'b0;
        stop_det   = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int   lat = 0;
        logic seen = 1'b0;
        exp_t e;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            if (done_s || err_s) seen = 1'b1;
        end
        chk({tag, "_event_seen"}, 32'(seen), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'd1);
            chk({tag, "_err"}, 32'(err_s), 32'(e.is_err));
            chk({tag, "_done"}, 32'(done_s), 32'(!e.is_err));
            chk({tag, "_bit_cnt"}, 32'(cnt_s), 32'(e.cnt));
            if (!e.is_err)
                chk({tag, "_data"}, rxbuf >> (32 - e.width), e.data);
        end
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [5:0] cnt,
                            input logic [31:0] data, input int unsigned width);
        exp_t e;
        e.is_err = is_err;
        e.cnt    = cnt;
        e.data   = data;
        e.width  = width;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_size_o"}, 32'(size_o_s), 32'd0);
        chk({tag, "_bit_cnt"}, 32'(cnt_s), 32'd0);
        chk({tag, "_ack_drive"}, 32'(ack_s), 32'd0);
        chk({tag, "_busy"}, 32'(busy_s), 32'd0);
        chk({tag, "_done"}, 32'(done_s), 32'd0);
        chk({tag, "_err"}, 32'(err_s), 32'd0);
        chk({tag, "_rload"}, 32'(rload_s), 32'd0);
    endtask

    initial begin
        logic        rl;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // size 8 with ACK, 0xA5 LSB first
        w = 32'hA5;
        rl_cnt = 0; ackslot_cnt = 0;
        send_start(8'd8);
        chk("t1_busy_after_start", 32'(busy_s), 32'd1);
        chk("t1_size_o", 32'(size_o_s), 32'd8);
        push_exp(1'b0, 6'd8, 32'hA5, 8);
        for (int i = 0; i < 8; i++) strobe(w[i], 1'b0, 1'b0, rl);
        chk("t1_ack_drive_in_slot", 32'(ack_s), 32'd1);
        strobe(1'b0, 1'b0, 1'b0, rl);
        wait_result("t1");
        chk("t1_rload_count", 32'(rl_cnt), 32'd8);
        chk("t1_ack_slots", 32'(ackslot_cnt), 32'd1);
        chk("t1_done_one_cycle", 32'(done_s), 32'd0);
        chk("t1_busy_idle", 32'(busy_s), 32'd0);

        // size 32 with ACK, 0xDEADBEEF
        w = 32'hDEADBEEF;
        rl_cnt = 0; ackslot_cnt = 0;
        send_start(8'd32);
        push_exp(1'b0, 6'd32, 32'hDEADBEEF, 32);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) strobe(w[8*k+i], 1'b0, 1'b0, rl);
            strobe(1'b0, 1'b0, 1'b0, rl);
        end
        wait_result("t2");
        chk("t2_rload_count", 32'(rl_cnt), 32'd32);
        chk("t2_ack_slots", 32'(ackslot_cnt), 32'd4);

        // size 16 without ACK, start mid-word ignored
        sel = 1'b1;
        @(posedge clk); #1;
        w = 32'h3C96;
        rl_cnt = 0; ackslot_cnt = 0;
        send_start(8'd16);
        push_exp(1'b0, 6'd16, 32'h3C96, 16);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) size = 8'd8;
            strobe(w[i], (i == 7), 1'b0, rl);
        end
        wait_result("t3");
        chk("t3_rload_count", 32'(rl_cnt), 32'd16);
        chk("t3_no_ack_drive", 32'(ackslot_cnt), 32'd0);
        chk("t3_size_o_kept", 32'(size_o_s), 32'd16);

        // illegal sizes on ACK instance: 12 and 40
        sel = 1'b0;
        @(posedge clk); #1;
        send_start(8'd12);
        push_exp(1'b1, 6'd32, 32'd0, 8);
        chk("t4_busy_stays_low", 32'(busy_s), 32'd0);
        wait_result("t4_sz12");
        chk("t4_size_o_kept", 32'(size_o_s), 32'd32);
        send_start(8'd40);
        push_exp(1'b1, 6'd32, 32'd0, 8);
        wait_result("t4_sz40");
        chk("t4_sz40_size_o_kept", 32'(size_o_s), 32'd32);

        // abort by stop_det coincident with 6th strobe
        send_start(8'd16);
        push_exp(1'b1, 6'd5, 32'd0, 8);
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0, rl);
        strobe(1'b1, 1'b0, 1'b1, rl);
        chk("t5_rload_with_stop", 32'(rl), 32'd1);
        wait_result("t5");
        chk("t5_busy_idle", 32'(busy_s), 32'd0);
        chk("t5_ack_drive_low", 32'(ack_s), 32'd0);

        // reset mid-word, then a clean size 8 receive
        send_start(8'd32);
        for (int i = 0; i < 20; i++) strobe(i[0], 1'b0, 1'b0, rl);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_pulse_after_rst", 32'(done_s | err_s), 32'd0);
        end
        @(posedge clk); #1;
        w = 32'h5A;
        rl_cnt = 0; ackslot_cnt = 0;
        send_start(8'd8);
        push_exp(1'b0, 6'd8, 32'h5A, 8);
        for (int i = 0; i < 8; i++) strobe(w[i], 1'b0, 1'b0, rl);
        strobe(1'b0, 1'b0, 1'b0, rl);
        wait_result("t6");
        chk("t6_rload_count", 32'(rl_cnt), 32'd8);
        chk("t6_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_rx_word_ctrl.md
Name: i2c_rx_word_ctrl

Overview:
- Sequences the I2C receive path. Accepts a word-receive command of 8, 16 or 32 bits and counts sampled SDA bits from the line interface.
- Drives the receive shift buffer's load enable for exactly `size` data bits, inserts an ACK slot after every byte and reports completion or abort.
- Sits between the transceiver top-level FSM and the receive shift buffer.

Parameters:
- ACK_EN, 1, 1 = insert one ACK bit slot after each received byte; 0 = no ACK slots.
- SIZE_W, 8, width of the size command field.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- size  in  SIZE_W  word length in bits; legal values 8, 16, 32; captured on accepted start.
- bit_strobe  in  1  one-cycle pulse; SDA bit sampled this cycle (SCL rising edge detected upstream).
- stop_det  in  1  one-cycle pulse; STOP or repeated-START seen on bus.
- rload  out  1  load enable to the receive shift buffer; combinational = (state==RECV) & bit_strobe.
- size_o  out  SIZE_W  registered copy of the captured size, fed to the buffer size input.
- ack_drive  out  1  high throughout ACK state; pad logic pulls SDA low.
- busy  out  1  high in RECV or ACK.
- done  out  1  one-cycle pulse; word complete, buffer contents valid.
- err  out  1  one-cycle pulse; illegal size or abort by stop_det.
- bit_cnt  out  6  data bits received in the current word, 0..32.

Behaviour:
- Reset: state=IDLE; size_o=0, bit_cnt=0, ack_drive=0, busy=0, done=0, err=0. rload=0 because state is not RECV.
- IDLE:
  - start with size in {8,16,32}: capture size_o, clear bit_cnt, go to RECV next cycle. busy rises one cycle after start.
  - start with any other size: err pulse next cycle; stay IDLE; size_o unchanged.
- RECV:
  - Each bit_strobe: rload=1 in the same cycle, so the buffer shifts on the following negedge. bit_cnt increments on the posedge.
  - When the incremented bit_cnt is a multiple of 8:
    - ACK_EN=1: go to ACK.
    - ACK_EN=0 and bit_cnt==size_o: go to DONE.
    - ACK_EN=0 otherwise: stay in RECV.
- ACK:
  - ack_drive=1; rload=0. The next bit_strobe consumes the ACK slot and is not counted.
  - On that strobe: go to DONE if bit_cnt==size_o, else return to RECV.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. bit_cnt holds its final value until the next accepted start.
- stop_det in RECV or ACK:
  - Abort: err pulse next cycle, go to IDLE, ack_drive drops.
  - Buffer contents are undefined and bit_cnt holds the partial count.
  - stop_det has priority over a bit_strobe in the same cycle; rload is still combinationally 1 in that cycle because state==RECV.
- stop_det in IDLE or DONE: ignored.
- start while busy or in DONE: ignored, no err.
- rst mid-word: immediate return to reset values at the next posedge; no done or err pulse.
- Width rules:
  - bit_cnt never exceeds size_o.
  - Byte boundary test uses bit_cnt[2:0]==0 after increment.
  - size comparison is full SIZE_W width, so 8'd40 is illegal.
- Latency: done is asserted one cycle after the cycle holding the last counted strobe (ACK_EN=0), or the ACK-slot strobe (ACK_EN=1).

Decomposition:
- Shared package holds:
  - State enum: IDLE, RECV, ACK, DONE.
  - Constants SZ_BYTE=8, SZ_HALF=16, SZ_WORD=32.
  - Function is_legal_size.
- No sub-module needed; a single FSM plus counter.
- The receive shift buffer is instantiated beside this block at transceiver top level, not inside it.

Test Plan:
- size=8, ACK_EN=1, 9 strobes:
  - 8 rload pulses, then ack_drive high until the 9th strobe.
  - done one cycle after the 9th strobe; bit_cnt=8.
  - Buffer low byte equals the serial pattern 0xA5 sent LSB-first.
- size=32, ACK_EN=1, 36 strobes:
  - ACK state entered 4 times; rload count=32.
  - done one cycle after strobe 36; buffer=0xDEADBEEF.
- size=16, ACK_EN=0, 16 strobes: done one cycle after strobe 16, no ack_drive; start pulsed mid-word is ignored.
- size=12 start: err pulse next cycle, busy stays 0, size_o keeps its previous value.
- size=16, stop_det after 5 strobes, same cycle as the 6th strobe: err pulse, IDLE, bit_cnt=5, no done.
- size=32, rst asserted after 20 strobes: all outputs at reset values next cycle. A following size=8 receive completes normally.
